// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcodes, instruction width and sequencer states shared by the sequencer.
package cpu_isa_pkg;
  localparam int INSTR_W = 8;
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_MUL    = 4'h4;
  localparam logic [3:0] OP_DIV    = 4'h5;
  localparam logic [3:0] OP_OUT_WR = 4'h6;
  localparam logic [3:0] OP_OUT_RD = 4'h7;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;
  typedef enum logic [2:0] {IDLE, FETCH, EVAL, TGT, ISSUE, HALTED} seq_state_e;
endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: program RAM with one write port and a registered (1-cycle) read.
module seq_prog_mem
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: steps a program counter through program RAM, resolves JUMP/HALT
// locally and hands every other byte to the decoder over valid/ready.
module instruction_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        issued_count
);
  seq_state_e         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic [15:0]        cnt_q;
  logic [INSTR_W-1:0] rdata;
  logic [ADDR_W-1:0]  raddr;
  logic               idle_like;
  assign idle_like = (state_q == IDLE) || (state_q == HALTED);
  // EVAL looks one byte ahead so a JUMP target is already read when TGT runs
  assign raddr = (state_q == EVAL) ? pc_q + 1'b1 : pc_q;
  seq_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (load_en && idle_like),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, HALTED: if (start) begin
          state_q <= FETCH;
          pc_q    <= '0;
          cnt_q   <= '0;
        end
        FETCH: state_q <= EVAL;
        EVAL: begin
          if (rdata[7:4] == OP_HALT) state_q <= HALTED;
          else if (rdata[7:4] == OP_JUMP) begin
            state_q <= TGT;
            pc_q    <= pc_q + 1'b1;
          end else begin
            state_q <= ISSUE;
            instr_q <= rdata;
            valid_q <= 1'b1;
          end
        end
        TGT: begin
          state_q <= FETCH;
          pc_q    <= rdata[ADDR_W-1:0];
        end
        ISSUE: if (instr_ready) begin
          state_q <= FETCH;
          valid_q <= 1'b0;
          pc_q    <= pc_q + 1'b1;
          cnt_q   <= cnt_q + {15'd0, ~&cnt_q};
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign instr_valid  = valid_q;
  assign instruction  = instr_q;
  assign pc           = pc_q;
  assign busy         = !idle_like;
  assign halted       = state_q == HALTED;
  assign issued_count = cnt_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed programs; expected issue order is queued, a monitor pops on each transfer.
module tb_instruction_sequencer;
  logic       clk = 0;
  logic       rst = 1;
  logic       load_en = 0;
  logic [4:0] load_addr = 0;
  logic [7:0] load_data = 0;
  logic       start = 0;
  logic       instr_ready = 0;
  logic       instr_valid;
  logic [7:0] instruction;
  logic [4:0] pc;
  logic       busy;
  logic       halted;
  logic [15:0] issued_count;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  instruction_sequencer #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .instr_ready(instr_ready), .instr_valid(instr_valid), .instruction(instruction),
    .pc(pc), .busy(busy), .halted(halted), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %0h expected none", instruction);
      end else chk("issue_order", int'(instruction), int'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick(1);
    load_en = 0;
  endtask

  task automatic go();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin tick(1); n++; end
    if (!instr_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin tick(1); n++; end
    chk("halt_reached", int'(halted), 1);
  endtask

  task automatic load_basic();
    wr(0, 8'h00); wr(1, 8'h10); wr(2, 8'h63); wr(3, 8'hF0);
  endtask

  initial begin
    tick(2);
    rst = 0;
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_count", int'(issued_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_instr", int'(instruction), 0);

    // basic program and start latency
    load_basic();
    exp_q = '{8'h00, 8'h10, 8'h63};
    instr_ready = 1;
    go();
    chk("busy_after_start", int'(busy), 1);
    tick(1);
    chk("valid_edge2", int'(instr_valid), 0);
    tick(1);
    chk("valid_edge3", int'(instr_valid), 1);
    chk("first_instr", int'(instruction), 8'h00);
    wait_halt(50);
    chk("t1_pc", int'(pc), 3);
    chk("t1_count", int'(issued_count), 3);
    chk("t1_valid", int'(instr_valid), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_queue", exp_q.size(), 0);

    // backpressure on the second instruction
    exp_q = '{8'h00, 8'h10, 8'h63};
    instr_ready = 0;
    go();
    wait_valid(20);
    chk("t2_first", int'(instruction), 8'h00);
    instr_ready = 1;
    tick(1);
    instr_ready = 0;
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      chk("stall_instr", int'(instruction), 8'h10);
      chk("stall_valid", int'(instr_valid), 1);
      chk("stall_pc", int'(pc), 1);
      chk("stall_count", int'(issued_count), 1);
      tick(1);
    end
    instr_ready = 1;
    tick(1);
    chk("t2_count_once", int'(issued_count), 2);
    wait_halt(50);
    chk("t2_count", int'(issued_count), 3);
    chk("t2_queue", exp_q.size(), 0);

    // JUMP skips its own byte and the target byte
    wr(0, 8'h40); wr(1, 8'hE0); wr(2, 8'h03); wr(3, 8'h50); wr(4, 8'hF0);
    exp_q = '{8'h40, 8'h50};
    go();
    wait_halt(50);
    chk("t3_pc", int'(pc), 4);
    chk("t3_count", int'(issued_count), 2);
    chk("t3_queue", exp_q.size(), 0);

    // all-zero program wraps without halting
    for (int i = 0; i < 32; i++) wr(5'(i), 8'h00);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(8'h00);
    go();
    wait_valid(20);
    tick(120);
    chk("t4_count", int'(issued_count), 40);
    chk("t4_pc_wrapped", int'(pc), 8);
    chk("t4_not_halted", int'(halted), 0);
    rst = 1;
    tick(1);
    rst = 0;
    chk("t4_queue", exp_q.size(), 0);

    // JUMP at the last address takes its target from address 0
    wr(0, 8'h05); wr(1, 8'hE0); wr(2, 8'h1E); wr(5, 8'hF0); wr(30, 8'h20); wr(31, 8'hE0);
    exp_q = '{8'h05, 8'h20};
    go();
    wait_halt(60);
    chk("t4b_pc", int'(pc), 5);
    chk("t4b_count", int'(issued_count), 2);
    chk("t4b_queue", exp_q.size(), 0);

    // reset mid-handshake, then rerun from retained memory
    load_basic();
    instr_ready = 0;
    go();
    wait_valid(20);
    rst = 1;
    tick(1);
    rst = 0;
    chk("t5_valid", int'(instr_valid), 0);
    chk("t5_pc", int'(pc), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_halted", int'(halted), 0);
    chk("t5_count", int'(issued_count), 0);
    exp_q = '{8'h00, 8'h10, 8'h63};
    instr_ready = 1;
    go();
    wait_halt(50);
    chk("t5_rerun_count", int'(issued_count), 3);
    chk("t5_queue", exp_q.size(), 0);

    // writes while busy are dropped; writes while halted land
    exp_q = '{8'h00, 8'h10, 8'h63};
    go();
    tick(1);
    wr(2, 8'hF0);
    wait_halt(50);
    chk("t6_busy_pc", int'(pc), 3);
    chk("t6_busy_count", int'(issued_count), 3);
    wr(2, 8'hF0);
    exp_q = '{8'h00, 8'h10};
    go();
    wait_halt(50);
    chk("t6_halt_pc", int'(pc), 2);
    chk("t6_halt_count", int'(issued_count), 2);
    chk("t6_queue", exp_q.size(), 0);

    // same-cycle load and start: the first fetch sees the new byte
    load_en = 1; load_addr = 0; load_data = 8'hF0; start = 1;
    tick(1);
    load_en = 0; start = 0;
    chk("t7_busy", int'(busy), 1);
    wait_halt(20);
    chk("t7_pc", int'(pc), 0);
    chk("t7_count", int'(issued_count), 0);
    chk("t7_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
